// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master and anything that talks to it.
package spi_pkg;

  localparam int FRAME_W = 10;
  localparam int DATA_W  = 8;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CTRL,
    ST_SHIFT,
    ST_HOLD,
    ST_TURN,
    ST_RECV,
    ST_GAP
  } state_t;

endpackage

// File: rtl/spi_master.sv
// Single-clock SPI frame master: 10-bit {op, payload} frames out on MOSI and,
// for read-data frames, an 8-bit response sampled from MISO after a turnaround.
//
// state | meaning
// IDLE  | SS_n high, cmd_ready high, waiting for a command
// CTRL  | SS_n low, MOSI presents op[1] one cycle ahead of the frame
// SHIFT | 10 frame bits on MOSI, MSB first
// HOLD  | one trailing cycle before release (non read-data frames)
// TURN  | RD_TURN cycles of slave turnaround
// RECV  | 8 MISO samples, MSB first
// GAP   | SS_n high for GAP cycles before returning to IDLE
module spi_master
  import spi_pkg::*;
#(
  parameter int RD_TURN = 2,
  parameter int GAP     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO
);

  localparam logic [CNT_W-1:0] SHIFT_LOAD = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD  = CNT_W'(RD_TURN - 1);
  localparam logic [CNT_W-1:0] RECV_LOAD  = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP - 1);

  state_t              state, state_nxt;
  op_t                 op_q;
  logic [CNT_W-1:0]    cnt, cnt_load;
  logic [FRAME_W-1:0]  tx_sr;
  logic [DATA_W-1:0]   rx_sr;
  logic [DATA_W-1:0]   rsp_q;
  logic                run;
  logic                accept;
  logic                cnt_done;

  assign accept    = cmd_valid & cmd_ready;
  assign cnt_done  = (cnt == '0);
  // run keeps cmd_ready low while in reset and for the cycle up to the first edge
  assign cmd_ready = run & (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign SS_n      = (state == ST_IDLE) | (state == ST_GAP);
  assign MOSI      = ((state == ST_CTRL) | (state == ST_SHIFT)) & tx_sr[FRAME_W-1];
  // rx_sr already holds the full byte during the pulse; rsp_q keeps it afterwards
  assign rsp_data  = rsp_valid ? rx_sr : rsp_q;

  always_comb begin
    state_nxt = state;
    cnt_load  = '0;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_CTRL;
      ST_CTRL: begin
        state_nxt = ST_SHIFT;
        cnt_load  = SHIFT_LOAD;
      end
      ST_SHIFT: begin
        if (cnt_done) begin
          if (op_q == RD_DATA) begin
            state_nxt = ST_TURN;
            cnt_load  = TURN_LOAD;
          end else begin
            state_nxt = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        state_nxt = ST_GAP;
        cnt_load  = GAP_LOAD;
      end
      ST_TURN: begin
        if (cnt_done) begin
          state_nxt = ST_RECV;
          cnt_load  = RECV_LOAD;
        end
      end
      ST_RECV: begin
        if (cnt_done) begin
          state_nxt = ST_GAP;
          cnt_load  = GAP_LOAD;
        end
      end
      ST_GAP:   if (cnt_done) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      op_q      <= WR_ADDR;
      cnt       <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rsp_q     <= '0;
      rsp_valid <= 1'b0;
      run       <= 1'b0;
    end else begin
      state     <= state_nxt;
      run       <= 1'b1;
      rsp_valid <= (state == ST_RECV) & cnt_done;

      // Reload on every state change; otherwise count down and park at zero
      if (state_nxt != state) begin
        cnt <= cnt_load;
      end else if (!cnt_done) begin
        cnt <= cnt - 1'b1;
      end

      if (accept) begin
        op_q  <= op_t'(cmd_op);
        tx_sr <= {cmd_op, cmd_data};
      end else if (state == ST_SHIFT) begin
        tx_sr <= {tx_sr[FRAME_W-2:0], 1'b0};
      end

      if (state == ST_RECV) begin
        rx_sr <= {rx_sr[DATA_W-2:0], MISO};
      end

      if (rsp_valid) begin
        rsp_q <= rx_sr;
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench: three spi_master builds with different turnaround/gap,
// each talking to a behavioural register-file slave, checked against a command model.
module tb_spi_master;
  import spi_pkg::*;

  localparam int N_DUT = 3;
  localparam int TURN_T [N_DUT] = '{2, 1, 7};
  localparam int GAP_T  [N_DUT] = '{1, 3, 2};
  localparam int BUDGET = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N_DUT-1:0] cmd_valid, cmd_ready, rsp_valid, busy, ss_n, mosi;
  logic [1:0] cmd_op [N_DUT];
  logic [7:0] cmd_data [N_DUT];
  logic [7:0] rsp_data [N_DUT];

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0]  exp_frame [N_DUT][$];
  logic [7:0]  exp_rsp   [N_DUT][$];
  logic [7:0]  mdl_mem   [N_DUT][256];
  logic [7:0]  mdl_addr  [N_DUT];
  int          frames_seen [N_DUT];
  int          drv_sent    [N_DUT];
  logic [10:0] last_bits   [N_DUT];
  int          last_len    [N_DUT];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
    localparam int RT     = TURN_T[gi];
    localparam int GP     = GAP_T[gi];
    localparam int RD_LEN = 1 + FRAME_W + RT + DATA_W;

    logic       miso;
    logic [7:0] s_mem [256];
    logic [7:0] s_addr;
    logic [7:0] s_byte;
    logic [7:0] last_rsp;
    logic [10:0] bits;
    logic [9:0] fr;
    logic [7:0] er;
    int         pos;
    int         hi_cnt;
    int         p;
    bit         seen;

    spi_master #(.RD_TURN(RT), .GAP(GP)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid[gi]),
      .cmd_ready (cmd_ready[gi]),
      .cmd_op    (cmd_op[gi]),
      .cmd_data  (cmd_data[gi]),
      .rsp_valid (rsp_valid[gi]),
      .rsp_data  (rsp_data[gi]),
      .busy      (busy[gi]),
      .SS_n      (ss_n[gi]),
      .MOSI      (mosi[gi]),
      .MISO      (miso)
    );

    initial begin
      for (int k = 0; k < 256; k++) s_mem[k] = 8'h00;
      s_addr = 8'h00; miso = 1'b0; pos = 0; hi_cnt = 0; seen = 0;
      last_rsp = 8'h00; bits = '0;
    end

    // Slave model and frame monitor; everything observed mid-cycle on the falling edge
    always @(negedge clk) begin
      if (!rst_n) begin
        pos = 0; hi_cnt = 0; seen = 0; last_rsp = 8'h00; miso = 1'b0;
        exp_frame[gi].delete();
        exp_rsp[gi].delete();
        chk($sformatf("d%0d reset ss_n", gi), ss_n[gi], 1'b1);
        chk($sformatf("d%0d reset rsp_valid", gi), rsp_valid[gi], 1'b0);
      end else if (!ss_n[gi]) begin
        if (pos == 0) begin
          frames_seen[gi]++;
          if (seen) chk($sformatf("d%0d gap cycles >= %0d (%0d)", gi, GP + 1, hi_cnt),
                        hi_cnt >= GP + 1, 1'b1);
        end
        if (pos <= FRAME_W) bits[FRAME_W - pos] = mosi[gi];
        p = pos - (1 + FRAME_W + RT);
        s_byte = s_mem[s_addr];
        miso = (p >= 0 && p < DATA_W) ? s_byte[DATA_W - 1 - p] : 1'b0;
        chk($sformatf("d%0d busy in frame", gi), busy[gi], 1'b1);
        chk($sformatf("d%0d rsp_valid in frame", gi), rsp_valid[gi], 1'b0);
        chk($sformatf("d%0d rsp_data hold", gi), rsp_data[gi], last_rsp);
        pos++;
      end else begin
        miso = 1'b0;
        chk($sformatf("d%0d mosi idle", gi), mosi[gi], 1'b0);
        if (pos > 0) begin
          fr = bits[FRAME_W-1:0];
          last_bits[gi] = bits;
          last_len[gi] = pos;
          chk($sformatf("d%0d ctrl bit", gi), bits[FRAME_W], bits[FRAME_W-1]);
          chk($sformatf("d%0d frame expected", gi), exp_frame[gi].size() > 0, 1'b1);
          if (exp_frame[gi].size() > 0)
            chk($sformatf("d%0d frame bits", gi), fr, exp_frame[gi].pop_front());
          chk($sformatf("d%0d ss_n low cycles", gi), pos, (fr[9:8] == 2'b11) ? RD_LEN : 12);
          if (fr[9:8] == 2'b11) begin
            chk($sformatf("d%0d rsp_valid pulse", gi), rsp_valid[gi], 1'b1);
            chk($sformatf("d%0d rsp expected", gi), exp_rsp[gi].size() > 0, 1'b1);
            if (exp_rsp[gi].size() > 0) begin
              er = exp_rsp[gi].pop_front();
              chk($sformatf("d%0d rsp_data", gi), rsp_data[gi], er);
              last_rsp = er;
            end
          end else begin
            chk($sformatf("d%0d no rsp_valid for write", gi), rsp_valid[gi], 1'b0);
            chk($sformatf("d%0d rsp_data hold", gi), rsp_data[gi], last_rsp);
          end
          case (fr[9:8])
            2'b00, 2'b10: s_addr = fr[7:0];
            2'b01:        s_mem[s_addr] = fr[7:0];
            default:      ;
          endcase
          pos = 0; seen = 1; hi_cnt = 1;
        end else begin
          hi_cnt++;
          chk($sformatf("d%0d rsp_valid idle", gi), rsp_valid[gi], 1'b0);
          chk($sformatf("d%0d rsp_data hold", gi), rsp_data[gi], last_rsp);
        end
      end
    end
  end

  // Called on a falling edge; returns on the falling edge of the first frame cycle
  task automatic send(input int i, input logic [1:0] op, input logic [7:0] d, input bit keep);
    int t;
    cmd_op[i] = op;
    cmd_data[i] = d;
    cmd_valid[i] = 1'b1;
    t = 0;
    while (!cmd_ready[i] && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("d%0d accept within budget", i), t < BUDGET, 1'b1);
    if (t < BUDGET) begin
      exp_frame[i].push_back({op, d});
      case (op)
        2'b00, 2'b10: mdl_addr[i] = d;
        2'b01:        mdl_mem[i][mdl_addr[i]] = d;
        default:      exp_rsp[i].push_back(mdl_mem[i][mdl_addr[i]]);
      endcase
      drv_sent[i]++;
    end
    @(posedge clk);
    @(negedge clk);
    if (!keep) cmd_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int t;
    t = 0;
    while ((busy[i] || !cmd_ready[i]) && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("d%0d idle within budget", i), t < BUDGET, 1'b1);
  endtask

  task automatic run_random(input int i, input int n);
    logic [1:0] op;
    logic [7:0] d;
    for (int k = 0; k < n; k++) begin
      op = 2'($urandom_range(0, 3));
      d  = (op == 2'b00 || op == 2'b10) ? 8'($urandom_range(0, 7)) : 8'($urandom);
      send(i, op, d, (k != n - 1) && ($urandom_range(0, 2) == 0));
    end
    wait_idle(i);
  endtask

  initial begin
    logic [7:0] v;
    int base;
    cmd_valid = '0;
    for (int i = 0; i < N_DUT; i++) begin
      cmd_op[i] = 2'b00; cmd_data[i] = 8'h00; mdl_addr[i] = 8'h00;
      frames_seen[i] = 0; drv_sent[i] = 0; last_bits[i] = '0; last_len[i] = 0;
      for (int k = 0; k < 256; k++) mdl_mem[i][k] = 8'h00;
    end

    repeat (3) @(negedge clk);
    for (int i = 0; i < N_DUT; i++) begin
      chk($sformatf("d%0d rst mosi", i), mosi[i], 1'b0);
      chk($sformatf("d%0d rst cmd_ready", i), cmd_ready[i], 1'b0);
      chk($sformatf("d%0d rst busy", i), busy[i], 1'b0);
      chk($sformatf("d%0d rst rsp_data", i), rsp_data[i], 8'h00);
    end
    #1 rst_n = 1'b1;
    #1 chk("cmd_ready before first edge", cmd_ready, 3'b000);
    @(posedge clk);
    #1 chk("cmd_ready after first edge", cmd_ready, 3'b111);
    @(negedge clk);

    // Write-address 0x3C: exact MOSI pattern from the SS_n fall
    send(0, 2'b00, 8'h3C, 0);
    wait_idle(0);
    chk("op00 mosi sequence", last_bits[0], 11'b000_0011_1100);
    chk("op00 ss_n low length", last_len[0], 12);

    // Write 0xA5 at 0x3C, read it back through the slave
    send(0, 2'b01, 8'hA5, 0);
    send(0, 2'b10, 8'h3C, 0);
    send(0, 2'b11, 8'h00, 0);
    wait_idle(0);
    chk("readback 0xA5", rsp_data[0], 8'hA5);

    // All-ones then all-zeros response on every turnaround build
    for (int i = 0; i < N_DUT; i++) begin
      send(i, 2'b00, 8'h10, 0);
      send(i, 2'b01, 8'hFF, 0);
      send(i, 2'b10, 8'h10, 0);
      send(i, 2'b11, 8'h00, 0);
      wait_idle(i);
      chk($sformatf("d%0d readback 0xFF", i), rsp_data[i], 8'hFF);
      send(i, 2'b01, 8'h00, 0);
      send(i, 2'b11, 8'h00, 0);
      wait_idle(i);
      chk($sformatf("d%0d readback 0x00", i), rsp_data[i], 8'h00);
    end

    // cmd_valid held across three commands
    base = frames_seen[0];
    send(0, 2'b00, 8'h20, 1);
    send(0, 2'b01, 8'h5A, 1);
    send(0, 2'b10, 8'h20, 0);
    wait_idle(0);
    chk("held valid acceptances", frames_seen[0] - base, 3);
    send(0, 2'b11, 8'h00, 0);
    wait_idle(0);
    chk("readback 0x5A", rsp_data[0], 8'h5A);

    // Reset in the middle of a read-data frame
    send(0, 2'b11, 8'h00, 0);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst ss_n", ss_n[0], 1'b1);
    chk("async rst mosi", mosi[0], 1'b0);
    chk("async rst cmd_ready", cmd_ready[0], 1'b0);
    chk("async rst busy", busy[0], 1'b0);
    chk("async rst rsp_valid", rsp_valid[0], 1'b0);
    chk("async rst rsp_data", rsp_data[0], 8'h00);
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1 chk("cmd_ready low until edge", cmd_ready[0], 1'b0);
    @(posedge clk);
    #1 chk("cmd_ready after reset edge", cmd_ready[0], 1'b1);
    @(negedge clk);
    v = 8'($urandom);
    send(0, 2'b00, 8'h55, 0);
    send(0, 2'b01, v, 0);
    send(0, 2'b10, 8'h55, 0);
    send(0, 2'b11, 8'h00, 0);
    wait_idle(0);
    chk("post-reset readback", rsp_data[0], v);

    fork
      run_random(0, 40);
      run_random(1, 40);
      run_random(2, 40);
    join

    repeat (4) @(negedge clk);
    for (int i = 0; i < N_DUT; i++) begin
      chk($sformatf("d%0d frames vs commands", i), frames_seen[i], drv_sent[i]);
      chk($sformatf("d%0d frames left", i), exp_frame[i].size(), 0);
      chk($sformatf("d%0d responses left", i), exp_rsp[i].size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
